// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared state/entry types and parity helper for the parity stages
package parity_pkg;

  localparam int DEFAULT_DATA_W = 32;
  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR-reduce unchanged.
  localparam int PARITY_MAX_W = 64;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Buffer entry layout at the default data width.
  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] data;
    logic                      err;
  } parity_entry_t;

  // Even parity is the XOR-reduce of the data; odd parity is its inverse.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_check_stage_if.sv
// rtl/parity_check_stage_if.sv - input/output word handshakes of the parity check stage
interface parity_check_stage_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_parity;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_parity, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_parity, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/parity_skid_fifo.sv
// rtl/parity_skid_fifo.sv - 2-entry valid/ready buffer, head entry always on pop_data
module parity_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  // push_ready depends only on occupancy, so there is no path from pop_ready
  assign push_ready = (cnt_q != 2'd2);
  assign pop_valid  = (cnt_q != 2'd0);
  assign pop_data   = head_q;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // Next head/tail/occupancy; push+pop only happens at occupancy 1, new word becomes head
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_data;
        else               tail_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: head_d = push_data;
      default: ;
    endcase
  end

  // Buffer registers; reset discards any stored words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/parity_check_stage.sv
// rtl/parity_check_stage.sv - parity check with error tagging, sticky error/halt, optional PARITY_ERR_CNT_EN error counter
module parity_check_stage
  import parity_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ODD         = 0,
  parameter int HALT_ON_ERR = 1
`ifdef PARITY_ERR_CNT_EN
  , parameter int CNT_W     = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  parity_check_stage_if.slave   bus,
  input  logic                  clr_err,
  output logic                  err_sticky,
  output logic                  halted
`ifdef PARITY_ERR_CNT_EN
  , output logic [CNT_W-1:0]    err_count
`endif
);
  // Entry stored in the buffer at this instance's data width (DATA_W up to PARITY_MAX_W)
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } word_t;

  state_t                  state_q, state_d;
  logic                    sticky_q, sticky_d;
  logic                    run, acc, word_err, fifo_push_ready;
  logic [PARITY_MAX_W-1:0] data_ext;
  word_t                   push_word, pop_word;

  assign run          = (state_q == RUN);
  assign bus.in_ready = fifo_push_ready && run;
  assign acc          = bus.in_valid && bus.in_ready;
  assign data_ext     = PARITY_MAX_W'(bus.in_data);
  assign word_err     = (calc_parity(data_ext, ODD != 0) != bus.in_parity);
  assign push_word    = '{data: bus.in_data, err: word_err};

  parity_skid_fifo #(
    .W($bits(word_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid && run),
    .push_ready (fifo_push_ready),
    .push_data  (push_word),
    .pop_valid  (bus.out_valid),
    .pop_ready  (bus.out_ready),
    .pop_data   (pop_word)
  );

  assign bus.out_data = pop_word.data;
  assign bus.out_err  = pop_word.err;
  assign err_sticky   = sticky_q;
  assign halted       = (state_q == HALT);

  // Next state and sticky flag; an erroneous accept wins over a same-cycle clear
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    if (clr_err)         sticky_d = 1'b0;
    if (acc && word_err) sticky_d = 1'b1;
    unique case (state_q)
      RUN:  if (acc && word_err && (HALT_ON_ERR != 0)) state_d = HALT;
      HALT: if (clr_err) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating error count; clear then increment gives 1 on a same-cycle error
  always_comb begin
    cnt_d = cnt_q;
    if (clr_err) cnt_d = '0;
    if (acc && word_err && (cnt_d != '1)) cnt_d = cnt_d + CNT_W'(1);
  end

  // Error counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`endif
endmodule

// File: tb/tb_parity_check_stage.sv
// tb/tb_parity_check_stage.sv - bench for parity_check_stage: even/halting and odd/non-halting instances against a reference model
module tb_parity_check_stage;
  logic clk = 1'b0;
  logic rst;
  logic clr_err;
  always #5 clk = ~clk;

  parity_check_stage_if #(.DATA_W(32)) b0 ();
  parity_check_stage_if #(.DATA_W(32)) b1 ();
  logic sticky0, sticky1, halted0, halted1;
`ifdef PARITY_ERR_CNT_EN
  logic [7:0] cnt0;
  logic [1:0] cnt1;
`endif

  parity_check_stage #(
    .DATA_W(32), .ODD(0), .HALT_ON_ERR(1)
`ifdef PARITY_ERR_CNT_EN
    , .CNT_W(8)
`endif
  ) u_even (
    .clk(clk), .rst(rst), .bus(b0.slave), .clr_err(clr_err),
    .err_sticky(sticky0), .halted(halted0)
`ifdef PARITY_ERR_CNT_EN
    , .err_count(cnt0)
`endif
  );

  parity_check_stage #(
    .DATA_W(32), .ODD(1), .HALT_ON_ERR(0)
`ifdef PARITY_ERR_CNT_EN
    , .CNT_W(2)
`endif
  ) u_odd (
    .clk(clk), .rst(rst), .bus(b1.slave), .clr_err(clr_err),
    .err_sticky(sticky1), .halted(halted1)
`ifdef PARITY_ERR_CNT_EN
    , .err_count(cnt1)
`endif
  );

  int passes = 0;
  int total  = 0;

  // Reference model: per instance, a list of buffered {data, err} words and flags
  int          m_odd     [2] = '{0, 1};
  int          m_halt_en [2] = '{1, 0};
  int          m_cmax    [2] = '{255, 3};
  logic [31:0] m_data    [2][2];
  bit          m_err     [2][2];
  int          m_cnt     [2];
  bit          m_sticky  [2];
  bit          m_halted  [2];
  int          m_errs    [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit word_err(input int k, input logic [31:0] d, input bit p);
    bit expected_p;
    expected_p = (($countones(d) % 2) == 1);
    if (m_odd[k] != 0) expected_p = !expected_p;
    return expected_p != p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_sticky[k] = 0; m_halted[k] = 0; m_errs[k] = 0;
    end
  endtask

  task automatic compare_all(input int k);
    string s;
    s = (k == 0) ? "even" : "odd";
    check($sformatf("%s.in_ready", s), 32'(k == 1 ? b1.in_ready : b0.in_ready),
          32'(m_cnt[k] < 2 && !m_halted[k]));
    check($sformatf("%s.out_valid", s), 32'(k == 1 ? b1.out_valid : b0.out_valid), 32'(m_cnt[k] > 0));
    if (m_cnt[k] > 0) begin
      check($sformatf("%s.out_data", s), (k == 1) ? b1.out_data : b0.out_data, m_data[k][0]);
      check($sformatf("%s.out_err", s), 32'(k == 1 ? b1.out_err : b0.out_err), 32'(m_err[k][0]));
    end
    check($sformatf("%s.err_sticky", s), 32'(k == 1 ? sticky1 : sticky0), 32'(m_sticky[k]));
    check($sformatf("%s.halted", s), 32'(k == 1 ? halted1 : halted0), 32'(m_halted[k]));
`ifdef PARITY_ERR_CNT_EN
    check($sformatf("%s.err_count", s), (k == 1) ? 32'(cnt1) : 32'(cnt0), 32'(m_errs[k]));
`endif
  endtask

  // One clock cycle: drive at the falling edge, compare, advance the model, wait for the next falling edge
  task automatic step(input bit iv, input logic [31:0] d, input bit p, input bit ordy, input bit clr);
    bit acc, err, pop;
    b0.in_valid = iv; b0.in_data = d; b0.in_parity = p; b0.out_ready = ordy;
    b1.in_valid = iv; b1.in_data = d; b1.in_parity = p; b1.out_ready = ordy;
    clr_err = clr;
    #1;
    for (int k = 0; k < 2; k++) begin
      compare_all(k);
      acc = iv && (m_cnt[k] < 2) && !m_halted[k];
      err = word_err(k, d, p);
      pop = (m_cnt[k] > 0) && ordy;
      if (pop) begin
        m_data[k][0] = m_data[k][1]; m_err[k][0] = m_err[k][1]; m_cnt[k]--;
      end
      if (acc) begin
        m_data[k][m_cnt[k]] = d; m_err[k][m_cnt[k]] = err; m_cnt[k]++;
      end
      if (clr) begin
        m_sticky[k] = 0; m_halted[k] = 0; m_errs[k] = 0;
      end
      if (acc && err) begin
        m_sticky[k] = 1;
        if (m_halt_en[k] != 0) m_halted[k] = 1;
        if (m_errs[k] < m_cmax[k]) m_errs[k]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    check("arst.even.out_valid", 32'(b0.out_valid), 32'd0);
    check("arst.even.halted", 32'(halted0), 32'd0);
    check("arst.even.err_sticky", 32'(sticky0), 32'd0);
    check("arst.odd.out_valid", 32'(b1.out_valid), 32'd0);
    check("arst.odd.err_sticky", 32'(sticky1), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1; clr_err = 1'b0;
    b0.in_valid = 0; b0.in_data = '0; b0.in_parity = 0; b0.out_ready = 0;
    b1.in_valid = 0; b1.in_data = '0; b1.in_parity = 0; b1.out_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk); #1;
    check("reset.out_valid", 32'(b0.out_valid), 32'd0);
    check("reset.out_data", b0.out_data, 32'd0);
    check("reset.out_err", 32'(b0.out_err), 32'd0);
    check("reset.err_sticky", 32'(sticky0), 32'd0);
    check("reset.halted", 32'(halted0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean even-parity word appears one cycle after acceptance
    step(1, 32'd2, 1, 1, 0);
    check("t1.out_data", b0.out_data, 32'd2);
    check("t1.out_err", 32'(b0.out_err), 32'd0);
    check("t1.err_sticky", 32'(sticky0), 32'd0);
    step(0, 32'd0, 0, 1, 0);

    // Erroneous word halts intake until clr_err
    step(1, 32'd30, 1, 1, 0);
    check("t2.out_err", 32'(b0.out_err), 32'd1);
    check("t2.err_sticky", 32'(sticky0), 32'd1);
    check("t2.halted", 32'(halted0), 32'd1);
    check("t2.in_ready", 32'(b0.in_ready), 32'd0);
    step(1, 32'd5, 0, 1, 0);
    step(1, 32'd5, 0, 1, 0);
    step(0, 32'd0, 0, 1, 1);
    check("t2.in_ready_after_clr", 32'(b0.in_ready), 32'd1);
    check("t2.halted_after_clr", 32'(halted0), 32'd0);

    // Stalled output: third word refused, stored words drain in order
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      step(1, d, ^d, 0, 0);
    end
    check("t3.in_ready_full", 32'(b0.in_ready), 32'd0);
    step(0, 32'd0, 0, 0, 0);
    step(0, 32'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'd0, 0, 1, 0);

    // Odd-parity instance
    step(1, 32'd30, 1, 1, 0);
    check("t4.odd_ok", 32'(b1.out_err), 32'd0);
    step(1, 32'd30, 0, 1, 0);
    check("t4.odd_err", 32'(b1.out_err), 32'd1);
    step(0, 32'd0, 0, 1, 1);

    // Error counter saturation and clear-with-error on the non-halting instance
    for (int i = 0; i < 5; i++) step(1, 32'd30, 0, 1, 0);
`ifdef PARITY_ERR_CNT_EN
    check("t5.cnt_sat", 32'(cnt1), 32'd3);
`endif
    step(1, 32'd30, 0, 1, 1);
`ifdef PARITY_ERR_CNT_EN
    check("t5.cnt_clr_err", 32'(cnt1), 32'd1);
`endif
    step(0, 32'd0, 0, 1, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      step($urandom_range(0, 3) != 0, d, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end

    // Reset while two words are buffered and the even instance is halted
    step(0, 32'd0, 0, 1, 1);
    step(0, 32'd0, 0, 1, 0);
    step(0, 32'd0, 0, 1, 0);
    step(1, 32'd3, 0, 0, 0);
    step(1, 32'd30, 1, 0, 0);
    check("t6.halted_before", 32'(halted0), 32'd1);
    check("t6.valid_before", 32'(b0.out_valid), 32'd1);
    async_reset();
    step(0, 32'd0, 0, 1, 0);
    step(0, 32'd0, 0, 1, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/parity_check_stage.md
Name: parity_check_stage

Overview:
- Downstream consumer of the parity generator.
- Accepts 32-bit words, each with its attached parity bit, over a valid/ready handshake.
- Recomputes parity, tags each word with an error flag and forwards it through a 2-entry output buffer.
- Tracks errors with a sticky flag; on error it can optionally halt intake until software clears it.

Parameters:
- DATA_W, 32: width of data word.
- ODD, 0: 0 = even parity (parity bit = XOR-reduce of data); 1 = odd parity (inverted).
- HALT_ON_ERR, 1: 1 = stop accepting after an erroneous word until clr_err; 0 = never halt.
- CNT_W, 8: error counter width (only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept.
- in_data  in  DATA_W  data word.
- in_parity  in  1  parity bit attached upstream.
- out_valid  out  1  buffered word available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head-of-buffer data.
- out_err  out  1  parity mismatch flag for the head word.
- clr_err  in  1  single-cycle pulse: clear sticky error, leave HALT.
- err_sticky  out  1  set by any accepted erroneous word.
- halted  out  1  FSM in HALT.
- err_count  out  CNT_W  saturating error count (only with PARITY_ERR_CNT_EN).

Behaviour:
- Clock and reset: one clock; rst is asynchronous and active-high.
- Reset values: buffer empty, out_valid=0, out_data=0, out_err=0, err_sticky=0, halted=0, err_count=0, FSM=RUN.
- Transfers: accept when in_valid && in_ready; deliver when out_valid && out_ready.
- Error computation: exp = (^in_data) ^ ODD; err = exp != in_parity. This is combinational on the accepted word and stored alongside it.
- Buffer: 2-entry FIFO of {data, err}. out_* always reflect the head entry. out_data and out_err hold while out_valid && !out_ready.
- Latency: a word accepted at edge N appears on out_* after edge N (1 cycle) if the buffer was empty.
- in_ready = (occupancy < 2) && FSM==RUN. It has no combinational path from out_ready.
- Boundary cases:
  - Full buffer: in_ready=0.
  - Occupancy 1 with push and pop in the same cycle: occupancy stays 1 and the new word becomes head.
  - Empty buffer: out_valid=0.
- FSM RUN:
  - Accepting a word with err=1 sets err_sticky.
  - If HALT_ON_ERR=1, the next state is HALT. The erroneous word itself is still buffered and delivered.
- FSM HALT:
  - halted=1 and in_ready=0; the buffer keeps draining normally.
  - clr_err returns the FSM to RUN on the next edge and clears err_sticky.
- clr_err in RUN: clears err_sticky. If an erroneous word is accepted in the same cycle, the set wins: err_sticky=1, and the FSM goes to HALT if enabled.
- clr_err with rst: rst dominates.
- Reset mid-operation: buffered words are discarded and no partial output is held.
- With HALT_ON_ERR=0, the FSM never leaves RUN and halted stays 0.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined:
  - err_count increments on each accepted erroneous word and saturates at all-ones.
  - clr_err clears it.
  - clr_err together with an erroneous accept gives count=1.
- Undefined: no err_count port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package parity_pkg holds:
  - typedef for the state enum {RUN, HALT};
  - typedef for the buffer entry struct {data, err};
  - localparam for the default DATA_W;
  - a function computing parity with an odd/even select. The existing calculator also uses this function.
- One natural sub-module: parity_skid_fifo, the 2-entry valid/ready buffer parameterised on entry width.

Test Plan:
- Even mode (ODD=0), in_data=32'd2 with in_parity=1, out_ready=1 -> word out 1 cycle later with out_data=2, out_err=0; err_sticky stays 0.
- in_data=32'd30 (four ones) with in_parity=1, HALT_ON_ERR=1 -> out_err=1, err_sticky=1, halted=1, in_ready=0 until a clr_err pulse; in_ready=1 on the cycle after clr_err.
- out_ready=0 while pushing 3 words -> in_ready drops after 2 accepts; raising out_ready drains the words in order with stable out_data while stalled.
- ODD=1, in_data=32'd30 with in_parity=1 -> out_err=0; in_parity=0 -> out_err=1.
- PARITY_ERR_CNT_EN, CNT_W=2, HALT_ON_ERR=0, 5 erroneous words -> err_count saturates at 3; clr_err in the same cycle as a 6th error -> err_count=1.
- Assert rst while 2 words are buffered and the FSM is in HALT -> out_valid=0, halted=0, err_sticky=0 immediately (asynchronous), with no stale word after release.
